// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - receive-side monitor for a 4-digit multiplexed 7-segment bus
// Captures each anode strobe into a per-digit register, decodes to BCD and checks scan order/liveness.
module seg_scan_capture #(
    parameter int STABLE  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk_fast,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  an_in,
    input  logic        err_clr,
    output logic [31:0] dig_raw,
    output logic [15:0] dig_bcd,
    output logic [3:0]  dig_blank,
    output logic        frame_valid,
    output logic        scan_err,
    output logic        scan_lost
);

    localparam int SW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        HUNT = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    exp_idx;
    logic [3:0]    prev_an;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] to_cnt;

    logic          strobe_valid;
    logic          multi_cold;
    logic          same;
    logic [1:0]    idx;
    logic [1:0]    slot;
    logic [SW-1:0] stab_next;
    logic          capture;
    logic [TW-1:0] to_next;
    logic          order_err;
    logic          err_event;

    // Active-low segment decode; dp (bit 7) is ignored by the caller.
    function automatic logic [3:0] bcd_of(input logic [6:0] s);
        logic [3:0] d;
        case (s)
            7'h40:   d = 4'd0;
            7'h79:   d = 4'd1;
            7'h24:   d = 4'd2;
            7'h30:   d = 4'd3;
            7'h19:   d = 4'd4;
            7'h12:   d = 4'd5;
            7'h02:   d = 4'd6;
            7'h78:   d = 4'd7;
            7'h00:   d = 4'd8;
            7'h10:   d = 4'd9;
            default: d = 4'hF;
        endcase
        return d;
    endfunction

    always_comb begin
        strobe_valid = $onehot(~an_in);
        multi_cold   = !$onehot0(~an_in);
        same         = (an_in == prev_an);

        idx = 2'd0;
        case (an_in)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            4'b1110: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        // Index 0 (min_top) lives in the most significant slot of the packed outputs.
        slot = 2'd3 - idx;

        stab_next = '0;
        capture   = 1'b0;
        if (strobe_valid) begin
            if (!same)
                stab_next = SW'(1);
            else if (stab_cnt < SW'(STABLE))
                stab_next = stab_cnt + SW'(1);
            else
                stab_next = stab_cnt;
            capture = (stab_next == SW'(STABLE)) && (!same || (stab_cnt < SW'(STABLE)));
        end

        if (strobe_valid && !same)
            to_next = '0;
        else if (to_cnt != TW'(TIMEOUT))
            to_next = to_cnt + TW'(1);
        else
            to_next = to_cnt;

        order_err = capture && (state == SCAN) && (idx != exp_idx);
        err_event = multi_cold || order_err;
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            exp_idx     <= 2'd0;
            prev_an     <= 4'hF;
            stab_cnt    <= '0;
            to_cnt      <= '0;
            dig_raw     <= 32'hFFFF_FFFF;
            dig_bcd     <= 16'hFFFF;
            dig_blank   <= 4'hF;
            frame_valid <= 1'b0;
            scan_err    <= 1'b0;
            scan_lost   <= 1'b0;
        end else begin
            prev_an     <= an_in;
            stab_cnt    <= stab_next;
            to_cnt      <= to_next;
            scan_lost   <= (to_next == TW'(TIMEOUT));
            frame_valid <= 1'b0;

            if (err_event)
                scan_err <= 1'b1;
            else if (err_clr)
                scan_err <= 1'b0;

            if (capture) begin
                dig_raw[{slot, 3'b000} +: 8] <= seg_in;
                dig_bcd[{slot, 2'b00} +: 4]  <= bcd_of(seg_in[6:0]);
                dig_blank[slot]              <= (seg_in == 8'hFF);

                case (state)
                    HUNT: begin
                        if (idx == 2'd0) begin
                            state   <= SCAN;
                            exp_idx <= 2'd1;
                        end
                    end
                    SCAN: begin
                        if (idx == exp_idx) begin
                            exp_idx <= exp_idx + 2'd1;
                            if (idx == 2'd3)
                                frame_valid <= 1'b1;
                        end else if (idx == 2'd0) begin
                            // A misplaced frame start still resynchronises immediately.
                            exp_idx <= 2'd1;
                        end else begin
                            state   <= HUNT;
                            exp_idx <= 2'd0;
                        end
                    end
                    default: begin
                        state   <= HUNT;
                        exp_idx <= 2'd0;
                    end
                endcase
            end else if (to_next == TW'(TIMEOUT)) begin
                state   <= HUNT;
                exp_idx <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - directed bench with frame scoreboard for seg_scan_capture
module tb_seg_scan_capture;

    localparam int TO = 64;

    logic        clk_fast = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_in, seg3;
    logic [3:0]  an_in, an3;
    logic        err_clr, err_clr3;
    logic [31:0] dig_raw, raw3;
    logic [15:0] dig_bcd, bcd3;
    logic [3:0]  dig_blank, blank3;
    logic        frame_valid, fv3, scan_err, err3, scan_lost, lost3;

    typedef struct packed {
        logic [31:0] raw;
        logic [15:0] bcd;
        logic [3:0]  blank;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_e;
    int     n_checks = 0;
    int     n_errors = 0;

    always #5 clk_fast = ~clk_fast;

    seg_scan_capture #(.STABLE(1), .TIMEOUT(TO)) dut (
        .clk_fast(clk_fast), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .err_clr(err_clr), .dig_raw(dig_raw), .dig_bcd(dig_bcd), .dig_blank(dig_blank),
        .frame_valid(frame_valid), .scan_err(scan_err), .scan_lost(scan_lost)
    );

    seg_scan_capture #(.STABLE(3), .TIMEOUT(TO)) dut3 (
        .clk_fast(clk_fast), .rst_n(rst_n), .seg_in(seg3), .an_in(an3),
        .err_clr(err_clr3), .dig_raw(raw3), .dig_bcd(bcd3), .dig_blank(blank3),
        .frame_valid(fv3), .scan_err(err3), .scan_lost(lost3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] an, input logic [7:0] seg);
        an_in  = an;
        seg_in = seg;
        @(negedge clk_fast);
    endtask

    task automatic frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, input logic [15:0] bcd, input logic [3:0] blank);
        cyc(4'h7, s0);
        cyc(4'hB, s1);
        cyc(4'hD, s2);
        exp_q.push_back(frame_t'({s0, s1, s2, s3, bcd, blank}));
        cyc(4'hE, s3);
    endtask

    // Scoreboard: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk_fast) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $error("FAIL frame_valid_unexpected: observed=1 expected=0");
            end else begin
                mon_e = exp_q.pop_front();
                assert ({dig_raw, dig_bcd, dig_blank} === mon_e) else begin
                    n_errors++;
                    $error("FAIL frame_outputs: observed=%h expected=%h",
                           {dig_raw, dig_bcd, dig_blank}, mon_e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; an_in = 4'hF; seg_in = 8'hFF; err_clr = 1'b0;
        an3 = 4'hF; seg3 = 8'hFF; err_clr3 = 1'b0;
        repeat (2) @(negedge clk_fast);
        chk("rst_raw", dig_raw, 32'hFFFF_FFFF);
        chk("rst_bcd", dig_bcd, 16'hFFFF);
        chk("rst_blank", dig_blank, 4'hF);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", scan_err, 1'b0);
        chk("rst_lost", scan_lost, 1'b0);
        rst_n = 1'b1;

        // Basic 1,2,3,4 scanning and first-capture latency
        cyc(4'h7, 8'hF9);
        chk("first_raw", dig_raw, 32'hF9FF_FFFF);
        chk("first_bcd", dig_bcd, 16'h1FFF);
        chk("first_blank", dig_blank, 4'b0111);
        chk("first_fv", frame_valid, 1'b0);
        cyc(4'hB, 8'hA4);
        cyc(4'hD, 8'hB0);
        exp_q.push_back(frame_t'({32'hF9A4_B099, 16'h1234, 4'h0}));
        cyc(4'hE, 8'h99);
        chk("t1_bcd", dig_bcd, 16'h1234);
        chk("t1_err", scan_err, 1'b0);
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h1234, 4'h0);
        frame(8'hC0, 8'h92, 8'h82, 8'hF8, 16'h0567, 4'h0);
        frame(8'h80, 8'h10, 8'h40, 8'h7F, 16'h890F, 4'h0);

        // Blink on the minute digits
        frame(8'hFF, 8'hFF, 8'hB0, 8'h99, 16'hFF34, 4'b1100);
        chk("blink_on", dig_blank, 4'b1100);
        chk("blink_bcd", dig_bcd[15:8], 8'hFF);
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h1234, 4'b0000);
        chk("blink_off", dig_blank, 4'b0000);
        frame(8'hFF, 8'hFF, 8'hB0, 8'h99, 16'hFF34, 4'b1100);
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h1234, 4'b0000);

        // Order error 7,B,E
        cyc(4'h7, 8'hF9);
        cyc(4'hB, 8'hA4);
        chk("ord_pre", scan_err, 1'b0);
        cyc(4'hE, 8'h99);
        chk("ord_err", scan_err, 1'b1);
        err_clr = 1'b1;
        cyc(4'hF, 8'hFF);
        err_clr = 1'b0;
        chk("ord_clr", scan_err, 1'b0);
        frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 16'h1234, 4'h0);

        // Multi-cold anode, then clear racing against a new error
        cyc(4'h3, 8'h00);
        chk("multi_err", scan_err, 1'b1);
        chk("multi_raw", dig_raw, 32'hF9A4_B099);
        err_clr = 1'b1;
        cyc(4'h3, 8'h00);
        chk("err_wins", scan_err, 1'b1);
        cyc(4'hF, 8'hFF);
        err_clr = 1'b0;
        chk("multi_clr", scan_err, 1'b0);
        frame(8'hC0, 8'h92, 8'h82, 8'hF8, 16'h0567, 4'h0);

        // Timeout after a partial frame, then resume at index 0
        cyc(4'h7, 8'hF9);
        cyc(4'hB, 8'hA4);
        repeat (TO - 1) cyc(4'hF, 8'hFF);
        chk("lost_edge_lo", scan_lost, 1'b0);
        cyc(4'hF, 8'hFF);
        chk("lost_edge_hi", scan_lost, 1'b1);
        cyc(4'hF, 8'hFF);
        chk("lost_hold", scan_lost, 1'b1);
        cyc(4'h7, 8'hF9);
        chk("lost_clear", scan_lost, 1'b0);
        chk("lost_hunt", scan_err, 1'b0);
        cyc(4'hB, 8'hA4);
        cyc(4'hD, 8'hB0);
        exp_q.push_back(frame_t'({32'hF9A4_B099, 16'h1234, 4'h0}));
        cyc(4'hE, 8'h99);

        // Asynchronous reset in the middle of a frame
        cyc(4'h7, 8'hC0);
        cyc(4'hB, 8'h92);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_raw", dig_raw, 32'hFFFF_FFFF);
        chk("arst_bcd", dig_bcd, 16'hFFFF);
        chk("arst_blank", dig_blank, 4'hF);
        chk("arst_err", scan_err, 1'b0);
        @(negedge clk_fast);
        rst_n = 1'b1;
        an_in = 4'hF;
        cyc(4'hD, 8'hB0);
        chk("post_rst_raw", dig_raw, 32'hFFFF_B0FF);
        cyc(4'hE, 8'h99);
        chk("post_rst_err", scan_err, 1'b0);
        frame(8'h80, 8'h10, 8'h40, 8'h7F, 16'h890F, 4'h0);

        // STABLE=3 instance: glitch rejected, held strobe captured exactly once
        an3 = 4'hB; seg3 = 8'hA4;
        repeat (2) @(negedge clk_fast);
        an3 = 4'hF; seg3 = 8'hFF;
        @(negedge clk_fast);
        chk("stab_glitch", raw3, 32'hFFFF_FFFF);
        an3 = 4'hB; seg3 = 8'hA4;
        repeat (2) @(negedge clk_fast);
        chk("stab_two", raw3, 32'hFFFF_FFFF);
        @(negedge clk_fast);
        chk("stab_three", raw3, 32'hFFA4_FFFF);
        chk("stab_bcd", bcd3, 16'hF2FF);
        seg3 = 8'h00;
        repeat (3) @(negedge clk_fast);
        chk("stab_no_recap", raw3, 32'hFFA4_FFFF);

        chk("frames_pending", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
